prime_scanner: RTL and testbench

PRIME_SCANNER -- requirements
Module: prime_scanner

---
 rtl/prime_scanner.sv | 112 +++++++++++
 tb/tb_prime_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prime_scanner.sv
// Prime scanner: walks candidates lo..hi past an external combinational prime
// detector and streams each prime found through a one-deep valid/ready slot.
module prime_scanner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  output logic [3:0] a,
  input  logic       is_prime,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] hi_r;
  logic       slot_free_s;

  // The output slot can take a new item when it is empty or being emptied now.
  assign slot_free_s = (out_valid == 1'b0) | out_ready;

  // Scan sequencer; the candidate register drives a directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hi_r      <= 4'd0;
      a         <= 4'd0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hi_r  <= hi;
            a     <= lo;
            count <= 3'd0;
            if (lo <= hi) begin
              state_r <= SCAN;
              busy    <= 1'b1;
            end else begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        SCAN: begin
          if (slot_free_s) begin
            if (is_prime) begin
              out_data  <= a;
              out_valid <= 1'b1;
              count     <= count + 3'd1;
            end else begin
              out_valid <= 1'b0;
            end
            // Stop at hi rather than incrementing, so hi=15 never wraps to 0.
            if (a < hi_r) begin
              a <= a + 4'd1;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= SCAN;
          end
        end

        DRAIN: begin
          if (slot_free_s) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_scanner.sv
// Directed self-checking bench for prime_scanner with a table-based prime
// detector and a monitor that records every accepted output item.
module tb_prime_scanner;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] a;
  logic       is_prime;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [2:0] count;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt    = 0;
  int done_cnt    = 0;
  int cyc         = 0;
  logic [3:0] got[$];
  logic [3:0] exp_full[6];

  prime_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo(lo), .hi(hi), .a(a),
    .is_prime(is_prime), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .count(count)
  );

  function automatic logic prime4(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: prime4 = 1'b1;
      default:                             prime4 = 1'b0;
    endcase
  endfunction

  assign is_prime = prime4(a);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle (inputs settled), then advance to just after the next edge.
  task automatic cycle();
    @(negedge clk);
    if (out_valid && out_ready) got.push_back(out_data);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] l, input logic [3:0] h);
    got.delete();
    busy_cnt = 0;
    done_cnt = 0;
    lo    = l;
    hi    = h;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    cyc = 0;
    while (!done && cyc < max_cycles) begin
      cycle();
      cyc++;
    end
    check("done_reached", {7'd0, done}, 8'd1);
  endtask

  task automatic check_full_stream(input string tag);
    check({tag, "_nitems"}, 8'(got.size()), 8'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check({tag, "_item"}, {4'd0, got[i]}, {4'd0, exp_full[i]});
      else check({tag, "_item_missing"}, 8'hFF, {4'd0, exp_full[i]});
    end
  endtask

  initial begin
    exp_full[0] = 4'd2;  exp_full[1] = 4'd3;  exp_full[2] = 4'd5;
    exp_full[3] = 4'd7;  exp_full[4] = 4'd11; exp_full[5] = 4'd13;
    rst_n = 1'b1; start = 1'b0; lo = 4'd0; hi = 4'd0; out_ready = 1'b1;

    // Reset values appear without a clock edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_a", {4'd0, a}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_count", {5'd0, count}, 8'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Full range 0..15 with a ready consumer
    start_scan(4'd0, 4'd15);
    check("full_busy_first", {7'd0, busy}, 8'd1);
    check("full_a_first", {4'd0, a}, 8'd0);
    wait_done(40);
    check("full_cycles", 8'(cyc), 8'd17);
    check("full_busy_cnt", 8'(busy_cnt), 8'd17);
    check("full_busy_at_done", {7'd0, busy}, 8'd0);
    check("full_count", {5'd0, count}, 8'd6);
    check("full_a_no_wrap", {4'd0, a}, 8'd15);
    check_full_stream("full");
    cycle();
    check("full_done_pulse", {7'd0, done}, 8'd0);
    check("full_done_cnt", 8'(done_cnt), 8'd1);
    cycle();
    cycle();
    check("idle_hold_count", {5'd0, count}, 8'd6);
    check("idle_hold_data", {4'd0, out_data}, 8'd13);
    check("idle_hold_valid", {7'd0, out_valid}, 8'd0);

    // Single non-prime candidate
    start_scan(4'd8, 4'd8);
    wait_done(20);
    check("single_cycles", 8'(cyc), 8'd2);
    check("single_busy_cnt", 8'(busy_cnt), 8'd2);
    check("single_count", {5'd0, count}, 8'd0);
    check("single_nitems", 8'(got.size()), 8'd0);
    cycle();

    // Empty range lo>hi goes straight to DONE
    start_scan(4'd9, 4'd3);
    check("empty_done_next", {7'd0, done}, 8'd1);
    check("empty_busy", {7'd0, busy}, 8'd0);
    check("empty_count", {5'd0, count}, 8'd0);
    cycle();
    check("empty_done_gone", {7'd0, done}, 8'd0);
    check("empty_busy_cnt", 8'(busy_cnt), 8'd0);
    check("empty_nitems", 8'(got.size()), 8'd0);

    // Backpressure: consumer stalls 5 cycles
    out_ready = 1'b0;
    start_scan(4'd2, 4'd3);
    cycle();
    check("bp_latency_valid", {7'd0, out_valid}, 8'd1);
    check("bp_latency_data", {4'd0, out_data}, 8'd2);
    check("bp_a_next", {4'd0, a}, 8'd3);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_hold_data", {4'd0, out_data}, 8'd2);
      check("bp_hold_a", {4'd0, a}, 8'd3);
      check("bp_hold_count", {5'd0, count}, 8'd1);
    end
    out_ready = 1'b1;
    wait_done(20);
    check("bp_count", {5'd0, count}, 8'd2);
    check("bp_nitems", 8'(got.size()), 8'd2);
    if (got.size() == 2) begin
      check("bp_item0", {4'd0, got[0]}, 8'd2);
      check("bp_item1", {4'd0, got[1]}, 8'd3);
    end
    cycle();

    // Reset in the middle of a scan, then restart on a new range
    start_scan(4'd0, 4'd15);
    for (int i = 0; i < 6; i++) cycle();
    check("mid_a_before_rst", {4'd0, a}, 8'd6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_a", {4'd0, a}, 8'd0);
    check("mid_rst_data", {4'd0, out_data}, 8'd0);
    check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_count", {5'd0, count}, 8'd0);
    done_cnt = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("mid_no_done", 8'(done_cnt), 8'd0);
    start_scan(4'd10, 4'd13);
    wait_done(20);
    check("restart_count", {5'd0, count}, 8'd2);
    check("restart_nitems", 8'(got.size()), 8'd2);
    if (got.size() == 2) begin
      check("restart_item0", {4'd0, got[0]}, 8'd11);
      check("restart_item1", {4'd0, got[1]}, 8'd13);
    end
    cycle();

    // A second start during a scan must be ignored
    start_scan(4'd0, 4'd15);
    cycle();
    cycle();
    lo    = 4'd4;
    hi    = 4'd5;
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(40);
    check("restart_ignored_busy_cnt", 8'(busy_cnt), 8'd17);
    check("restart_ignored_count", {5'd0, count}, 8'd6);
    check_full_stream("restart_ignored");
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
